// File: rtl/scaler_pkg.sv
// Shared widths and packed-pixel helpers for the line scalers.
package scaler_pkg;

  // Pixel word is DWIDTH+1 bits wide; three channels of CW bits each.
  function automatic int dwidth(input int half_depth);
    return (half_depth != 0) ? 11 : 23;
  endfunction

  function automatic int chan_w(input int half_depth);
    return (half_depth != 0) ? 4 : 8;
  endfunction

  // Horizontal pair sum and 2x2 block sum widths.
  function automatic int sum_w(input int cw);
    return cw + 1;
  endfunction

  function automatic int tot_w(input int cw);
    return cw + 2;
  endfunction

  // LSB position of channel idx (0=R, 1=G, 2=B) in a word of w-bit channels.
  function automatic int chan_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/down2x_linebuf.sv
// Simple dual-port line buffer holding horizontal pair sums; registered read, no reset on contents.
module down2x_linebuf #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 27
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/down2x_box.sv
// 2:1 box-filter downscaler: averages each 2x2 block into one pixel, 1 clk after the block's 4th pixel.
// Define DOWN2X_ROUND_EN for round-half-up averaging; otherwise the average truncates.
module down2x_box
  import scaler_pkg::*;
#(
  parameter int LENGTH     = 1024,
  parameter int HALF_DEPTH = 0,
  localparam int DWIDTH    = dwidth(HALF_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce_in,
  input  logic [DWIDTH:0] inputpixel,
  input  logic            reset_line,
  input  logic            reset_frame,
  output logic            outvalid,
  output logic [DWIDTH:0] outpixel,
  output logic            out_sol
);

  localparam int CW = chan_w(HALF_DEPTH);
  localparam int SW = sum_w(CW);
  localparam int TW = tot_w(CW);
  localparam int XW = $clog2(LENGTH) + 1;
  localparam int AW = $clog2(LENGTH) - 1;
  localparam int BW = 3 * SW;
`ifdef DOWN2X_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic            old_reset_line;
  logic            old_reset_frame;
  logic            odd_line;
  logic            line_seen;
  logic [XW-1:0]   x;
  logic [DWIDTH:0] pix_even;

  logic            line_start;
  logic            frame_start;
  logic            cur_odd;
  logic            accept;
  logic            acc_even;
  logic            acc_odd;
  logic [XW-1:0]   cur_x;
  logic [AW-1:0]   addr;
  logic [BW-1:0]   pair_sum;
  logic [BW-1:0]   rd_data;
  logic [DWIDTH:0] avg;

  // The line-start pixel is itself accepted at x=0 with the new line parity.
  // line_seen keeps the first line after reset even.
  always_comb begin
    line_start  = ce_in & old_reset_line & ~reset_line;
    frame_start = line_start & old_reset_frame & ~reset_frame;
    cur_x       = line_start ? '0 : x;
    cur_odd     = line_start ? (~frame_start & line_seen & ~odd_line) : odd_line;
    accept      = ce_in & ~reset_line & ~cur_x[XW-1];
    acc_even    = accept & ~cur_x[0];
    acc_odd     = accept & cur_x[0];
    addr        = cur_x[AW:1];
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [SW-1:0] s;
    logic [TW-1:0] t;
    assign s = SW'(pix_even[chan_lo(c, CW) +: CW]) + SW'(inputpixel[chan_lo(c, CW) +: CW]);
    assign t = TW'(s) + TW'(rd_data[chan_lo(c, SW) +: SW]);
    assign pair_sum[chan_lo(c, SW) +: SW] = s;
    assign avg[chan_lo(c, CW) +: CW]      = CW'((t + TW'(RND)) >> 2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_reset_line  <= 1'b0;
      old_reset_frame <= 1'b0;
      odd_line        <= 1'b0;
      line_seen       <= 1'b0;
      x               <= '0;
      pix_even        <= '0;
      outvalid        <= 1'b0;
      outpixel        <= '0;
      out_sol         <= 1'b0;
    end else begin
      outvalid <= 1'b0;
      out_sol  <= 1'b0;
      if (ce_in) old_reset_line <= reset_line;
      if (line_start) begin
        old_reset_frame <= reset_frame;
        odd_line        <= cur_odd;
        line_seen       <= 1'b1;
      end
      // x stops at LENGTH because accept drops there.
      if (accept) x <= cur_x + 1'b1;
      else if (line_start) x <= '0;
      if (acc_even) pix_even <= inputpixel;
      if (acc_odd && cur_odd) begin
        outvalid <= 1'b1;
        outpixel <= avg;
        out_sol  <= (addr == '0);
      end
    end
  end

  // Even lines write pair sums; odd lines read them on the even-x pixel.
  down2x_linebuf #(
    .DEPTH(LENGTH / 2),
    .AW   (AW),
    .DW   (BW)
  ) u_linebuf (
    .clk    (clk),
    .wr_en  (acc_odd & ~cur_odd),
    .wr_addr(addr),
    .wr_data(pair_sum),
    .rd_en  (acc_even & cur_odd),
    .rd_addr(addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_down2x_box.sv
// Randomized scoreboard bench for down2x_box, 24-bit and 12-bit instances on one stimulus stream.
module tb_down2x_box;

  localparam int LEN = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_in;
  logic        reset_line;
  logic        reset_frame;
  logic [23:0] inputpixel;
  logic        outvalid;
  logic [23:0] outpixel;
  logic        out_sol;
  logic        h_outvalid;
  logic [11:0] h_outpixel;
  logic        h_out_sol;

  always #5 clk = ~clk;

  down2x_box #(.LENGTH(LEN), .HALF_DEPTH(0)) dut (
    .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(inputpixel),
    .reset_line(reset_line), .reset_frame(reset_frame),
    .outvalid(outvalid), .outpixel(outpixel), .out_sol(out_sol)
  );

  down2x_box #(.LENGTH(LEN), .HALF_DEPTH(1)) dut_h (
    .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(inputpixel[11:0]),
    .reset_line(reset_line), .reset_frame(reset_frame),
    .outvalid(h_outvalid), .outpixel(h_outpixel), .out_sol(h_out_sol)
  );

  typedef struct {
    logic [23:0] pix;
    logic        sol;
    int          cyc;
  } exp_t;

  exp_t q_f[$];
  exp_t q_h[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: line parity bookkeeping and the raw pixels of each stored pair.
  logic [23:0] bufa [LEN/2];
  logic [23:0] bufb [LEN/2];
  logic [23:0] pix_src [LEN+4];
  bit m_odd, m_seen, m_prf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean of four pixels per channel, from plain integer arithmetic.
  function automatic logic [23:0] avg4(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c, input logic [23:0] d, input int cw);
    logic [23:0] r;
    int s, m;
    r = '0;
    m = (1 << cw) - 1;
    for (int ch = 0; ch < 3; ch++) begin
      s = ((int'(a) >> (ch*cw)) & m) + ((int'(b) >> (ch*cw)) & m)
        + ((int'(c) >> (ch*cw)) & m) + ((int'(d) >> (ch*cw)) & m);
`ifdef DOWN2X_ROUND_EN
      s = (s + 2) / 4;
`else
      s = s / 4;
`endif
      r = r | (24'(s) << (ch*cw));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && outvalid === 1'b1) begin
      if (q_f.size() == 0) check("full_unexpected_pulse", 32'(outpixel), 32'hDEAD);
      else begin
        e = q_f.pop_front();
        check("full_pixel", 32'(outpixel), 32'(e.pix));
        check("full_sol", 32'(out_sol), 32'(e.sol));
        check("full_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (reset_n === 1'b1 && out_sol === 1'b1) check("full_sol_no_valid", 32'(out_sol), 32'd0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && h_outvalid === 1'b1) begin
      if (q_h.size() == 0) check("half_unexpected_pulse", 32'(h_outpixel), 32'hDEAD);
      else begin
        e = q_h.pop_front();
        check("half_pixel", 32'(h_outpixel), 32'(e.pix[11:0]));
        check("half_sol", 32'(h_out_sol), 32'(e.sol));
        check("half_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (reset_n === 1'b1 && h_out_sol === 1'b1) check("half_sol_no_valid", 32'(h_out_sol), 32'd0);
  end

  task automatic drive(input bit ce, input bit rl, input bit rf, input logic [23:0] p);
    @(negedge clk);
    ce_in       = ce;
    reset_line  = rl;
    reset_frame = rf;
    inputpixel  = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce_in = 1'b0;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pix_src[i] = 24'($urandom);
  endtask

  task automatic fill_const(input int n, input logic [23:0] v);
    for (int i = 0; i < n; i++) pix_src[i] = v;
  endtask

  // Blank, then n pixels from pix_src with gap idle clocks between strobes.
  task automatic do_line(input int n, input bit rf, input int gap);
    exp_t e;
    int k;
    for (int j = 0; j < 2; j++) begin
      idle(gap);
      drive(1'b1, 1'b1, rf, 24'($urandom));
    end
    if (!m_seen || (m_prf && !rf)) m_odd = 1'b0;
    else m_odd = !m_odd;
    m_seen = 1'b1;
    m_prf  = rf;
    for (int i = 0; i < n; i++) begin
      idle(gap);
      drive(1'b1, 1'b0, rf, pix_src[i]);
      if (i < LEN && (i % 2) == 1) begin
        k = i / 2;
        if (m_odd) begin
          e.sol = (k == 0);
          e.cyc = cyc + 1;
          e.pix = avg4(bufa[k], bufb[k], pix_src[i-1], pix_src[i], 8);
          q_f.push_back(e);
          e.pix = avg4(bufa[k] & 24'hFFF, bufb[k] & 24'hFFF,
                       pix_src[i-1] & 24'hFFF, pix_src[i] & 24'hFFF, 4);
          q_h.push_back(e);
        end else begin
          bufa[k] = pix_src[i-1];
          bufb[k] = pix_src[i];
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ce_in   = 1'b0;
    #1;
    check("rst_outvalid", 32'(outvalid), 32'd0);
    check("rst_outpixel", 32'(outpixel), 32'd0);
    check("rst_out_sol", 32'(out_sol), 32'd0);
    check("rst_half_outpixel", 32'(h_outpixel), 32'd0);
    check("rst_half_outvalid", 32'(h_outvalid), 32'd0);
    m_seen = 1'b0;
    m_odd  = 1'b0;
    m_prf  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int nl;
    reset_n     = 1'b0;
    ce_in       = 1'b0;
    reset_line  = 1'b1;
    reset_frame = 1'b0;
    inputpixel  = '0;
    m_seen = 1'b0; m_odd = 1'b0; m_prf = 1'b0;
    repeat (3) @(negedge clk);
    check("init_outvalid", 32'(outvalid), 32'd0);
    check("init_outpixel", 32'(outpixel), 32'd0);
    check("init_out_sol", 32'(out_sol), 32'd0);
    check("init_half_outvalid", 32'(h_outvalid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vertical blank line, then frame start with directed R values.
    fill_rand(1); do_line(1, 1'b1, 0);
    fill_rand(4);
    for (int i = 0; i < 4; i++) pix_src[i][7:0] = 8'(10 * (i + 1));
    do_line(4, 1'b0, 0);
    fill_rand(4);
    for (int i = 0; i < 4; i++) pix_src[i][7:0] = 8'(10 * (i + 3));
    do_line(4, 1'b0, 0);

    // Rounding corners: block sums 5 and 7 on every channel.
    pix_src[0] = 24'h010101; pix_src[1] = 24'h010101; pix_src[2] = 24'h010101; pix_src[3] = 24'h020202;
    do_line(4, 1'b0, 0);
    pix_src[0] = 24'h010101; pix_src[1] = 24'h020202; pix_src[2] = 24'h020202; pix_src[3] = 24'h020202;
    do_line(4, 1'b0, 0);

    // Over-long lines fill the whole buffer and exercise x saturation.
    fill_rand(LEN + 3); do_line(LEN + 3, 1'b0, 0);
    fill_rand(LEN + 3); do_line(LEN + 3, 1'b0, 0);

    // ce_in every third clock, 5-pixel lines.
    for (int l = 0; l < 4; l++) begin
      fill_rand(5); do_line(5, 1'b0, 2);
    end

    // Previous frame ends on an even line; two blank lines precede the new frame.
    fill_rand(6); do_line(6, 1'b0, 0);
    fill_rand(1); do_line(1, 1'b1, 0);
    fill_rand(1); do_line(1, 1'b1, 0);
    fill_rand(8); do_line(8, 1'b0, 0);
    fill_rand(8); do_line(8, 1'b0, 0);

    // Random frames with random line widths and strobe spacing.
    for (int f = 0; f < 3; f++) begin
      fill_rand(1); do_line(1, 1'b1, $urandom_range(0, 2));
      nl = $urandom_range(3, 6);
      for (int l = 0; l < nl; l++) begin
        fill_rand(LEN + 3);
        do_line($urandom_range(1, LEN + 3), 1'b0, $urandom_range(0, 2));
      end
    end

    // Full-scale and zero pixels.
    fill_rand(1); do_line(1, 1'b1, 0);
    fill_const(8, 24'hFFFFFF); do_line(8, 1'b0, 0);
    fill_const(8, 24'hFFFFFF); do_line(8, 1'b0, 1);
    fill_const(8, 24'h000000); do_line(8, 1'b0, 0);
    fill_const(8, 24'h000000); do_line(8, 1'b0, 0);

    // Reset in the middle of an odd line after one of two pairs.
    fill_rand(1); do_line(1, 1'b1, 0);
    fill_rand(4); do_line(4, 1'b0, 0);
    fill_rand(2); do_line(2, 1'b0, 0);
    idle(3);
    do_reset();
    fill_rand(4); do_line(4, 1'b0, 0);
    fill_rand(4); do_line(4, 1'b0, 0);

    idle(6);
    check("full_queue_drained", 32'(q_f.size()), 32'd0);
    check("half_queue_drained", 32'(q_h.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
